iter_add_seq: RTL and testbench
===============================

Name: iter_add_seq

Overview:
- Multi-cycle adder controller built around a single WIDTH-bit half-add stage (sum = x XOR y, carry = x AND y).
- Iterates the stage, feeding the left-shifted carry back in, until no carry remains. Produces a + b + cin.
- Valid/ready handshakes on both sides, so it can sit between the ALU operand register and the ALU result mux as a low-area add unit.

Parameters:
- WIDTH, 32, operand and result width in bits (WIDTH >= 2).
- ITER_W, $clog2(WIDTH+2), width of the iteration counter. Derived; must not be overridden.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  asynchronous reset, active-low.
- clear  input  1  synchronous abort. Returns the block to IDLE from any state.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- cin  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed (two's-complement) overflow.
- iter_count  output  ITER_W  number of half-add steps used.
- busy  output  1  high in RUN.

Behaviour:
- Clocking/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, cout 0, overflow 0, iter_count 0, busy 0. Internal x, y and sign registers are cleared to 0.
- States: IDLE, RUN, DONE.
- Outputs decoded from state: in_ready = (state == IDLE); busy = (state == RUN); out_valid = (state == DONE).
- Half-add step on working registers x, y:
  - x <= x ^ y
  - y <= (x & y) << 1 (MSB of x & y is discarded)
  - cout <= cout | (x & y)[WIDTH-1]
  - iter_count <= iter_count + 1
- IDLE:
  - On in_valid && in_ready, perform step 1 directly from the operands: x <= a ^ b; y <= ((a & b) << 1) | cin; cout <= (a & b)[WIDTH-1]; iter_count <= 1.
  - Latch sa = a[WIDTH-1] and sb = b[WIDTH-1].
  - Next state is DONE if the new y == 0, else RUN.
- RUN:
  - Perform one step per cycle.
  - Go to DONE on the edge where the newly computed y == 0.
  - in_valid is ignored.
- DONE:
  - result = x.
  - overflow = (sa == sb) && (x[WIDTH-1] != sa), registered on entry to DONE.
  - result, cout, overflow and iter_count are held stable while out_valid && !out_ready.
  - On out_valid && out_ready, go to IDLE; in_ready rises the following cycle. No same-cycle re-accept.
- Latency:
  - out_valid rises after the iter_count-th rising edge, counting the accept edge as edge 1.
  - Minimum 1 cycle (no carries). Maximum WIDTH+1 cycles (all-ones + 0 + cin=1).
  - iter_count never exceeds WIDTH+1.
- Outputs outside DONE: result, cout, overflow and iter_count keep their last values after leaving DONE. They are only meaningful while out_valid = 1.
- clear:
  - Takes priority over all handshakes.
  - Next state is IDLE and all registers return to reset values.
  - A simultaneous in_valid is not accepted.
- Reset mid-operation: rst_n low in any state immediately forces reset values. No result is produced for the aborted operation.
- Arithmetic: modulo 2^WIDTH.
  - cout equals bit WIDTH of the true sum a + b + cin.
  - overflow is correct for cin = 1.

Test Plan:
- 3 + 5, cin = 0: accept edge, then out_valid after edge 4. Expect result 8, cout 0, overflow 0, iter_count 4.
- 0xFFFFFFFF + 0x1, cin = 0: expect result 0, cout 1, overflow 0, iter_count 32. Then 0xFFFFFFFF + 0, cin = 1: expect result 0, cout 1, iter_count 33 (maximum latency).
- 0x7FFFFFFF + 1: expect result 0x80000000, overflow 1, cout 0, iter_count 32. Also 0x80000000 + 0x80000000: expect result 0, cout 1, overflow 1.
- 0 + 0, cin = 0: out_valid on the cycle after accept, iter_count 1. Hold out_ready low 5 cycles with in_valid high: outputs stay stable, in_ready stays 0, no second accept. Raise out_ready: in_ready is 1 on the next cycle.
- Start 0xFFFFFFFF + 1, then pulse clear after 10 cycles: back to IDLE on the next cycle, out_valid never asserted, in_ready 1. Repeat with rst_n pulled low mid-RUN: outputs are at reset values immediately. A subsequent 3 + 5 completes correctly.
- Back-to-back stream of 1000 random a, b, cin with random out_ready: every result, cout and overflow matches the reference sum, and every iter_count <= 33.

Source files
------------

// File: rtl/iter_add_seq.sv
// Multi-cycle adder that iterates a single half-add stage until no carry remains.
// Result is a + b + cin, with carry-out, signed overflow and the number of steps used.
module iter_add_seq #(
  parameter  int WIDTH  = 32,
  localparam int ITER_W = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              cout,
  output logic              overflow,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_next;
  logic [WIDTH-1:0]    x, x_next, y, y_next;
  logic [WIDTH-1:0]    ab, xy;
  logic                sa, sa_next, sb, sb_next;
  logic                cout_r, cout_next, ovf_r, ovf_next;
  logic [ITER_W-1:0]   cnt, cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      x      <= x_next;
      y      <= y_next;
      sa     <= sa_next;
      sb     <= sb_next;
      cout_r <= cout_next;
      ovf_r  <= ovf_next;
      cnt    <= cnt_next;
    end
  end

  // The accept cycle performs the first step straight from the operands, folding cin into bit 0.
  always_comb begin
    state_next = state;
    x_next     = x;
    y_next     = y;
    sa_next    = sa;
    sb_next    = sb;
    cout_next  = cout_r;
    ovf_next   = ovf_r;
    cnt_next   = cnt;
    ab         = a & b;
    xy         = x & y;

    case (state)
      IDLE: begin
        if (in_valid) begin
          x_next     = a ^ b;
          y_next     = {ab[WIDTH-2:0], cin};
          cout_next  = ab[WIDTH-1];
          cnt_next   = ITER_W'(1);
          sa_next    = a[WIDTH-1];
          sb_next    = b[WIDTH-1];
          state_next = (y_next == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        x_next     = x ^ y;
        y_next     = {xy[WIDTH-2:0], 1'b0};
        cout_next  = cout_r | xy[WIDTH-1];
        cnt_next   = cnt + ITER_W'(1);
        state_next = (y_next == '0) ? DONE : RUN;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state != DONE && state_next == DONE)
      ovf_next = (sa_next == sb_next) && (x_next[WIDTH-1] != sa_next);

    // Abort wins over everything, including a same-cycle accept.
    if (clear) begin
      state_next = IDLE;
      x_next     = '0;
      y_next     = '0;
      sa_next    = 1'b0;
      sb_next    = 1'b0;
      cout_next  = 1'b0;
      ovf_next   = 1'b0;
      cnt_next   = '0;
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state == RUN);
  assign out_valid  = (state == DONE);
  assign result     = x;
  assign cout       = cout_r;
  assign overflow   = ovf_r;
  assign iter_count = cnt;

endmodule

// File: tb/tb_iter_add_seq.sv
// Scoreboard bench for iter_add_seq: the driver queues expected results on accept,
// the monitor pops and compares on every output handshake.
module tb_iter_add_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid, cin;
  logic          fixed_ready, rand_ready, rnd_bit;
  logic          out_ready;
  logic [W-1:0]  a, b;
  logic          in_ready, out_valid, cout, overflow, busy;
  logic [W-1:0]  result;
  logic [5:0]    iter_count;

  typedef struct {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
    int           iter;
    bit           exact;
    int           dec_cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  logic prev_valid = 1'b0;

  assign out_ready = rand_ready ? rnd_bit : fixed_ready;

  iter_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow),
    .iter_count(iter_count), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Monitor: latency is measured from the driver's decision cycle to the first out_valid cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) first_cyc = cyc;
      if (out_valid && out_ready) begin
        check_output("pending_txn", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check_output("result", 64'(result), 64'(e.res));
          check_output("cout", 64'(cout), 64'(e.co));
          check_output("overflow", 64'(overflow), 64'(e.ov));
          if (e.exact) begin
            check_output("iter_count", 64'(iter_count), 64'(e.iter));
            check_output("latency", 64'(first_cyc - e.dec_cyc), 64'(e.iter));
          end else begin
            check_output("iter_bound", 64'(iter_count >= 6'd1 && iter_count <= 6'd33), 64'd1);
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                                input bit push, input bit exact, input int e_iter,
                                input logic [W-1:0] e_res, input logic e_co, input logic e_ov,
                                input bit keep);
    int waited = 0;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    while (!in_ready && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check_output("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{e_res, e_co, e_ov, e_iter, exact, cyc});
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic apply_random();
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   s;
    ra = $urandom;
    rb = $urandom;
    rc = 1'($urandom_range(0, 1));
    s  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    apply_stimulus(ra, rb, rc, 1'b1, 1'b0, 0, s[W-1:0], s[W],
                   (ra[W-1] == rb[W-1]) && (s[W-1] != ra[W-1]), 1'b0);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check_output("drain", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    fixed_ready = 1'b1; rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_result", 64'(result), 64'd0);
    check_output("rst_iter", 64'(iter_count), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(32'd3, 32'd5, 1'b0, 1, 1, 4, 32'd8, 1'b0, 1'b0, 0);
    check_output("busy_in_run", 64'(busy), 64'd1);
    check_output("in_ready_in_run", 64'(in_ready), 64'd0);
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1, 1, 32, 32'd0, 1'b1, 1'b0, 0);
    apply_stimulus(32'hFFFF_FFFF, 32'd0, 1'b1, 1, 1, 33, 32'd0, 1'b1, 1'b0, 0);
    apply_stimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1, 1, 32, 32'h8000_0000, 1'b0, 1'b1, 0);
    apply_stimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1, 1, 1, 32'd0, 1'b1, 1'b1, 0);
    drain(200);

    // Back-pressure with in_valid held high: nothing may be accepted while DONE.
    fixed_ready = 1'b0;
    apply_stimulus(32'd0, 32'd0, 1'b0, 1, 1, 1, 32'd0, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("hold_out_valid", 64'(out_valid), 64'd1);
      check_output("hold_in_ready", 64'(in_ready), 64'd0);
      check_output("hold_result", 64'(result), 64'd0);
      check_output("hold_iter", 64'(iter_count), 64'd1);
    end
    @(posedge clk); #1;
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    check_output("in_ready_after_pop", 64'(in_ready), 64'd1);
    check_output("no_same_cycle_accept", 64'(busy | out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Abort with clear mid-RUN.
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_output("clear_in_ready", 64'(in_ready), 64'd1);
    check_output("clear_busy", 64'(busy), 64'd0);
    check_output("clear_iter", 64'(iter_count), 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check_output("clear_no_output", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-RUN.
    apply_stimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 0, 0, 32'd0, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_output("arst_in_ready", 64'(in_ready), 64'd1);
    check_output("arst_busy", 64'(busy), 64'd0);
    check_output("arst_out_valid", 64'(out_valid), 64'd0);
    check_output("arst_result", 64'(result), 64'd0);
    check_output("arst_cout", 64'(cout), 64'd0);
    check_output("arst_iter", 64'(iter_count), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(32'd3, 32'd5, 1'b0, 1, 1, 4, 32'd8, 1'b0, 1'b0, 0);
    drain(200);

    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) apply_random();
    drain(2000);
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
